countdown_ctrl: RTL and testbench

- Control stage that sits directly upstream of the digitTimer chain.
- Sequences load, start, pause and expiry of the countdown. Issues the one-cycle reconfig pulse to every digit and drives the prescaled borrow-down tick into the least-significant digit.
- Consumes the least-significant digit's no-borrow-down flag to detect that the whole count has reached zero.
- Raises the expired indication consumed by display and alarm logic.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 61 ++++++
 rtl/countdown_ctrl.sv | 143 ++++++++++++++
 tb/tb_countdown_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer slice.
//   state_t          : encoded FSM states of countdown_ctrl (also the debug code
//                      driven on countdown_ctrl.state)
//   TICK_DIV_DEFAULT : default clk cycles per countdown tick
//   PW_DEFAULT       : default prescaler width (2**PW_DEFAULT >= TICK_DIV_DEFAULT)
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam int TICK_DIV_DEFAULT = 100;
    localparam int PW_DEFAULT       = 7;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Counts 0..TICK_DIV-1 while enabled and emits a registered one-cycle wrap
// pulse in the cycle after the count passes TICK_DIV-1. When not enabled the
// count holds its value, so a paused countdown resumes mid-period.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   enable in   advance the count this cycle
//   clear  in   force the count to 0 (wins over enable, kills any wrap)
//   wrap   out  registered one-cycle pulse after a wrap
//   count  out  current (held) count
// -----------------------------------------------------------------------------
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int PW       = PW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clear,
    output logic          wrap,
    output logic [PW-1:0] count
);

    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count_reg, count_next;
    logic          wrap_reg, wrap_next;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            if (count_reg == LAST) begin
                count_next = '0;
                wrap_next  = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign wrap  = wrap_reg;
    assign count = count_reg;

endmodule

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Control stage in front of the digit chain: sequences load / start / pause /
// expiry, pulses reconfig to every digit, and feeds the prescaled borrow tick
// into the least-significant digit.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   load         in   (re)load starting digits; level, re-pulses while held
//   start        in   start (from ARMED) or resume (from PAUSED)
//   pause        in   freeze the countdown (RUN only)
//   clear        in   return from EXPIRED to IDLE
//   preset_zero  in   presented starting digits are all zero; sampled with load
//   done_in      in   noBorrowDown of the least-significant digit
//   reconfig     out  one-cycle reload pulse to all digits
//   borrow_down  out  one-cycle tick to the least-significant digit
//   running      out  state is RUN
//   paused       out  state is PAUSED
//   expired      out  state is EXPIRED
//   expire_pulse out  one-cycle pulse on entry to EXPIRED
//   state        out  encoded FSM state (debug)
// -----------------------------------------------------------------------------
module countdown_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int PW       = PW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       preset_zero,
    input  logic       done_in,
    output logic       reconfig,
    output logic       borrow_down,
    output logic       running,
    output logic       paused,
    output logic       expired,
    output logic       expire_pulse,
    output logic [2:0] state
);

    state_t state_reg, state_next;
    logic   zero_pending_reg, zero_pending_next;
    logic   reconfig_reg, reconfig_next;
    logic   expire_pulse_reg, expire_pulse_next;

    logic          presc_enable;
    logic          presc_clear;
    logic          presc_wrap;
    // Held count is kept on the prescaler for probing; the FSM only needs wrap.
    logic [PW-1:0] held_count_unused;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .PW       (PW)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (presc_enable),
        .clear  (presc_clear),
        .wrap   (presc_wrap),
        .count  (held_count_unused)
    );

    always_comb begin
        state_next        = state_reg;
        zero_pending_next = zero_pending_reg;
        presc_enable      = 1'b0;
        presc_clear       = 1'b0;

        if (load) begin
            // Load overrides everything; clearing the prescaler also kills any
            // tick due this cycle, so reconfig and borrow_down never overlap.
            state_next        = ARMED;
            zero_pending_next = preset_zero;
            presc_clear       = 1'b1;
        end else begin
            case (state_reg)
                IDLE: ;
                ARMED: begin
                    presc_clear = 1'b1;
                    if (start) begin
                        // An all-zero preset never raises done_in on its own,
                        // so expire directly without issuing a borrow.
                        state_next = zero_pending_reg ? EXPIRED : RUN;
                    end
                end
                RUN: begin
                    // Prescaler only advances when neither expiry nor pause
                    // takes effect, so a coincident wrap yields no tick.
                    if (done_in) begin
                        state_next = EXPIRED;
                    end else if (pause) begin
                        state_next = PAUSED;
                    end else begin
                        presc_enable = 1'b1;
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_next = RUN;
                    end
                end
                EXPIRED: begin
                    if (clear) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        reconfig_next     = load;
        expire_pulse_next = (state_next == EXPIRED) && (state_reg != EXPIRED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            zero_pending_reg <= 1'b0;
            reconfig_reg     <= 1'b0;
            expire_pulse_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            zero_pending_reg <= zero_pending_next;
            reconfig_reg     <= reconfig_next;
            expire_pulse_reg <= expire_pulse_next;
        end
    end

    assign reconfig     = reconfig_reg;
    assign borrow_down  = presc_wrap;
    assign expire_pulse = expire_pulse_reg;
    assign running      = (state_reg == RUN);
    assign paused       = (state_reg == PAUSED);
    assign expired      = (state_reg == EXPIRED);
    assign state        = state_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
// Directed bench for countdown_ctrl with TICK_DIV=4. A two-digit chain model
// (loaded with 02 unless noted) supplies done_in; done_in can be overridden
// for the single-step vector table and the collision case.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       load, start, pause, clear, preset_zero;
    logic       done_in;
    logic       reconfig, borrow_down, running, paused, expired, expire_pulse;
    logic [2:0] state;

    // done_in source selection
    logic       ovr_en, ovr_val;

    // two-digit chain model
    logic [3:0] preset_d1, preset_d0;
    logic [3:0] d1, d0, nd1, nd0;
    logic       done_m;

    int checks = 0;
    int errors = 0;

    countdown_ctrl #(
        .TICK_DIV (TD),
        .PW       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .start        (start),
        .pause        (pause),
        .clear        (clear),
        .preset_zero  (preset_zero),
        .done_in      (done_in),
        .reconfig     (reconfig),
        .borrow_down  (borrow_down),
        .running      (running),
        .paused       (paused),
        .expired      (expired),
        .expire_pulse (expire_pulse),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign done_in = ovr_en ? ovr_val : done_m;

    always_comb begin
        nd0 = d0;
        nd1 = d1;
        if (d0 != 4'd0) begin
            nd0 = d0 - 4'd1;
        end else begin
            nd0 = 4'd9;
            nd1 = d1 - 4'd1;
        end
    end

    // Digits reset to 0 with noBorrowDown=1; update one cycle after a strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1     <= 4'd0;
            d0     <= 4'd0;
            done_m <= 1'b1;
        end else if (reconfig) begin
            d1     <= preset_d1;
            d0     <= preset_d0;
            done_m <= (preset_d1 == 4'd0) && (preset_d0 == 4'd0);
        end else if (borrow_down && !done_m) begin
            d1     <= nd1;
            d0     <= nd0;
            done_m <= (nd1 == 4'd0) && (nd0 == 4'd0);
        end
    end

    typedef struct {
        string name;
        bit    ld, st, ps, cl, pz, dn;
        int    es;
        bit    rc, bd, ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input bit ld, input bit st, input bit ps,
                                input bit cl, input bit pz, input bit dn, input int es,
                                input bit rc, input bit bd, input bit ep);
        vec_t v;
        v.name = n; v.ld = ld; v.st = st; v.ps = ps; v.cl = cl; v.pz = pz; v.dn = dn;
        v.es = es; v.rc = rc; v.bd = bd; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input bit ld, input bit st, input bit ps, input bit cl, input bit pz);
        load = ld; start = st; pause = ps; clear = cl; preset_zero = pz;
    endtask

    function automatic int outv();
        return {23'd0, state, reconfig, borrow_down, running, paused, expired, expire_pulse};
    endfunction

    function automatic int expv(input int es, input bit rc, input bit bd, input bit ep);
        logic [2:0] s;
        s = es[2:0];
        return {23'd0, s, rc, bd, (es == 2), (es == 3), (es == 4), ep};
    endfunction

    initial begin
        int borrows[$];
        int pulse_cnt, first_exp, viol, bcnt;

        rst = 1'b0;
        cmd(0, 0, 0, 0, 0);
        ovr_en = 1'b1; ovr_val = 1'b0;
        preset_d1 = 4'd0; preset_d0 = 4'd2;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outv(), expv(0, 0, 0, 0));
        rst = 1'b1;

        // ---- single-step vector table (done_in from table) ----
        //               name              ld st ps cl pz dn  st rc bd ep
        vecs.push_back(mk("idle_start",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle_pause",     0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle_clear",     0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle_done",      0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("load",           1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("load_held",      1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("armed_idle",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("armed_pause",    0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("armed_clear",    0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("armed_start",    0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_pause",      0, 0, 1, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("paused_done",    0, 0, 0, 0, 0, 1, 3, 0, 0, 0));
        vecs.push_back(mk("paused_clear",   0, 0, 0, 1, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("paused_st_ps",   0, 1, 1, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk("resume",         0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_cnt1",       0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_cnt2",       0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_cnt3",       0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_tick",       0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        vecs.push_back(mk("run_tick_end",   0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_load_all",   1, 1, 1, 1, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk("zero_start",     0, 1, 0, 0, 0, 0, 4, 0, 0, 1));
        vecs.push_back(mk("expired_level",  0, 0, 0, 0, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk("exp_st_ps",      0, 1, 1, 0, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk("exp_ld_cl_st",   1, 1, 0, 1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("armed_start2",   0, 1, 0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_clear",      0, 0, 0, 1, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk("run_done",       0, 0, 0, 0, 0, 1, 4, 0, 0, 1));
        vecs.push_back(mk("exp_clear",      0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            cmd(vecs[i].ld, vecs[i].st, vecs[i].ps, vecs[i].cl, vecs[i].pz);
            ovr_val = vecs[i].dn;
            step();
            chk(vecs[i].name, outv(), expv(vecs[i].es, vecs[i].rc, vecs[i].bd, vecs[i].ep));
        end
        cmd(0, 0, 0, 0, 0);
        ovr_val = 1'b0;
        ovr_en  = 1'b0;

        // ---- asynchronous reset mid-RUN ----
        cmd(1, 0, 0, 0, 0); step();
        cmd(0, 1, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0); step(); step();
        chk("pre_reset_run", outv(), expv(2, 0, 0, 0));
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_no_edge", outv(), expv(0, 0, 0, 0));
        step();
        chk("reset_held", outv(), expv(0, 0, 0, 0));
        rst = 1'b1;
        cmd(1, 0, 0, 0, 0); step();
        chk("reload_after_reset", outv(), expv(1, 1, 0, 0));
        cmd(0, 0, 0, 0, 0); step();
        chk("reconfig_one_cycle", outv(), expv(1, 0, 0, 0));

        // ---- full countdown from 02 ----
        cmd(0, 1, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0);
        chk("run_entry", outv(), expv(2, 0, 0, 0));
        pulse_cnt = 0; first_exp = -1; viol = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step();
            if (borrow_down) borrows.push_back(cyc);
            if (borrow_down && reconfig) viol++;
            if (expire_pulse) pulse_cnt++;
            if (expired && first_exp < 0) first_exp = cyc;
        end
        chk("borrow_count", borrows.size(), 2);
        chk("first_tick_cycle", (borrows.size() > 0) ? borrows[0] : -1, TD);
        chk("second_tick_cycle", (borrows.size() > 1) ? borrows[1] : -1, 2 * TD);
        chk("expiry_cycle", first_exp, 2 * TD + 2);
        chk("expire_pulse_count", pulse_cnt, 1);
        chk("expired_level_held", outv(), expv(4, 0, 0, 0));
        chk("reconfig_borrow_overlap", viol, 0);

        // ---- pause / resume with held prescaler ----
        cmd(0, 0, 0, 1, 0); step();
        chk("clear_to_idle", outv(), expv(0, 0, 0, 0));
        cmd(1, 0, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0); step();
        cmd(0, 1, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0);
        step(); step();
        cmd(0, 0, 1, 0, 0); step();
        cmd(0, 0, 0, 0, 0);
        chk("pause_enter", outv(), expv(3, 0, 0, 0));
        bcnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (borrow_down || state != 3'd3) bcnt++;
        end
        chk("paused_quiet", bcnt, 0);
        cmd(0, 1, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0);
        chk("resume_entry", outv(), expv(2, 0, 0, 0));
        step();
        chk("resume_plus1", outv(), expv(2, 0, 0, 0));
        step();
        chk("resume_first_tick", outv(), expv(2, 0, 1, 0));

        // ---- zero preset ----
        preset_d1 = 4'd0; preset_d0 = 4'd0;
        cmd(1, 0, 0, 0, 1); step();
        cmd(0, 0, 0, 0, 0); step();
        cmd(0, 1, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0);
        chk("zero_preset_expire", outv(), expv(4, 0, 0, 1));
        bcnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (borrow_down) bcnt++;
        end
        chk("zero_preset_no_borrow", bcnt, 0);

        // ---- done_in coincident with prescaler wrap ----
        preset_d1 = 4'd0; preset_d0 = 4'd5;
        ovr_en = 1'b1; ovr_val = 1'b0;
        cmd(1, 0, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0); step();
        cmd(0, 1, 0, 0, 0); step();
        cmd(0, 0, 0, 0, 0);
        step(); step(); step();
        ovr_val = 1'b1;
        step();
        chk("done_wrap_collision", outv(), expv(4, 0, 0, 1));
        step();
        chk("no_late_tick", outv(), expv(4, 0, 0, 0));
        ovr_val = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
